pipe_hazard_ctrl: RTL and testbench

//  Parametrised ID-stage control and hazard unit for the 5-stage pipeline. Decodes op/funct,

---
 rtl/phc_pkg.sv | 41 ++++
 rtl/phc_decode.sv | 72 +++++++
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phc_pkg.sv
// Shared decode constants, forwarding codes and FSM state for pipe_hazard_ctrl.
// Optional immediate ALU ops are enabled with PHC_IMM_ALU_EN.
package phc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EXA  = 2'b01;
  localparam logic [1:0] FWD_MEMA = 2'b10;
  localparam logic [1:0] FWD_MEMD = 2'b11;

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       regrt;
    logic [3:0] aluc;
  } ctl_t;

endpackage

// File: rtl/phc_decode.sv
// Combinational op/funct decoder producing the control bundle and source usage.
// PHC_IMM_ALU_EN adds ADDI/ANDI/ORI/XORI; otherwise those opcodes are illegal.
module phc_decode
  import phc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctl_t       ctl,
  output logic       illegal,
  output logic       rs_used,
  output logic       rt_used
);

  always_comb begin
    ctl     = '0;
    illegal = 1'b0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctl.wreg = 1'b1;
        rs_used  = 1'b1;
        rt_used  = 1'b1;
        case (funct)
          FN_ADD:  ctl.aluc = ALU_ADD;
          FN_SUB:  ctl.aluc = ALU_SUB;
          FN_AND:  ctl.aluc = ALU_AND;
          FN_OR:   ctl.aluc = ALU_OR;
          FN_XOR:  ctl.aluc = ALU_XOR;
          default: begin
            ctl     = '0;
            illegal = 1'b1;
            rs_used = 1'b0;
            rt_used = 1'b0;
          end
        endcase
      end
      op == OP_LW: begin
        ctl.wreg   = 1'b1;
        ctl.m2reg  = 1'b1;
        ctl.aluimm = 1'b1;
        ctl.regrt  = 1'b1;
        ctl.aluc   = ALU_ADD;
        rs_used    = 1'b1;
      end
      op == OP_SW: begin
        ctl.wmem   = 1'b1;
        ctl.aluimm = 1'b1;
        ctl.aluc   = ALU_ADD;
        rs_used    = 1'b1;
        rt_used    = 1'b1;
      end
`ifdef PHC_IMM_ALU_EN
      op == OP_ADDI, op == OP_ANDI,
      op == OP_ORI,  op == OP_XORI: begin
        ctl.wreg   = 1'b1;
        ctl.aluimm = 1'b1;
        ctl.regrt  = 1'b1;
        rs_used    = 1'b1;
        case (op)
          OP_ANDI: ctl.aluc = ALU_AND;
          OP_ORI:  ctl.aluc = ALU_OR;
          OP_XORI: ctl.aluc = ALU_XOR;
          default: ctl.aluc = ALU_ADD;
        endcase
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage control: decode, forwarding selects, load-use stall FSM, ID/EX register.
// Build option PHC_IMM_ALU_EN enables immediate ALU instructions in the decoder.
module pipe_hazard_ctrl
  import phc_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int ALUC_W     = 4,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] m_dest,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  output logic              stall,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic [ALUC_W-1:0] e_aluc,
  output logic              e_aluimm,
  output logic [REG_AW-1:0] e_dest,
  output logic [1:0]        e_fwda,
  output logic [1:0]        e_fwdb,
  output logic              e_illegal
);

  localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL - 1);

  ctl_t              dctl;
  logic              illegal;
  logic              rs_used;
  logic              rt_used;
  logic [REG_AW-1:0] dest;
  logic [1:0]        fwda;
  logic [1:0]        fwdb;
  logic              hazard;
  logic              load_ok;
  state_t            state;
  state_t            state_n;
  logic [1:0]        cnt;
  logic [1:0]        cnt_n;

  phc_decode u_dec (
    .op      (op),
    .funct   (funct),
    .ctl     (dctl),
    .illegal (illegal),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  assign dest = dctl.regrt ? rt : rd;

  // EX/MEM ALU result wins over anything older; loads in EX stall instead.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] r,
    input logic              used,
    input logic [REG_AW-1:0] ed,
    input logic              ew,
    input logic              em,
    input logic [REG_AW-1:0] md,
    input logic              mw,
    input logic              mm
  );
    logic [1:0] s;
    s = FWD_REG;
    if (used && r != '0) begin
      if (r == ed && ew && !em)
        s = FWD_EXA;
      else if (r == md && mw)
        s = mm ? FWD_MEMD : FWD_MEMA;
    end
    return s;
  endfunction

  assign fwda = fwd_sel(rs, rs_used, e_dest, e_wreg, e_m2reg,
                        m_dest, m_wreg, m_m2reg);
  assign fwdb = fwd_sel(rt, rt_used, e_dest, e_wreg, e_m2reg,
                        m_dest, m_wreg, m_m2reg);

  assign hazard = if_valid && e_wreg && e_m2reg
               && e_dest != '0
               && ((rs_used && rs == e_dest)
                || (rt_used && rt == e_dest));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    load_ok = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          stall = 1'b1;
          cnt_n = CNT_INIT;
          if (CNT_INIT != 2'd0)
            state_n = STALL;
        end else begin
          load_ok = if_valid;
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_n = cnt - 2'd1;
        if (cnt == 2'd1)
          state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_wmem    <= 1'b0;
      e_aluc    <= '0;
      e_aluimm  <= 1'b0;
      e_dest    <= '0;
      e_fwda    <= FWD_REG;
      e_fwdb    <= FWD_REG;
      e_illegal <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load_ok) begin
        e_wreg    <= dctl.wreg;
        e_m2reg   <= dctl.m2reg;
        e_wmem    <= dctl.wmem;
        e_aluc    <= ALUC_W'(dctl.aluc);
        e_aluimm  <= dctl.aluimm;
        e_dest    <= illegal ? '0 : dest;
        e_fwda    <= fwda;
        e_fwdb    <= fwdb;
        e_illegal <= illegal;
      end else begin
        e_wreg    <= 1'b0;
        e_m2reg   <= 1'b0;
        e_wmem    <= 1'b0;
        e_aluc    <= '0;
        e_aluimm  <= 1'b0;
        e_dest    <= '0;
        e_fwda    <= FWD_REG;
        e_fwdb    <= FWD_REG;
        e_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (LOAD_STALL 1..3) against an
// instruction-level pipeline model; honours PHC_IMM_ALU_EN in the model.
module tb_pipe_hazard_ctrl;

  localparam int NI = 3;

  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
    logic [4:0] dest;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       ill;
  } mctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_valid [NI];
  logic [5:0] op       [NI];
  logic [5:0] funct    [NI];
  logic [4:0] rs       [NI];
  logic [4:0] rt       [NI];
  logic [4:0] rd       [NI];
  logic [4:0] m_dest   [NI];
  logic       m_wreg   [NI];
  logic       m_m2reg  [NI];
  logic       stall    [NI];
  logic       e_wreg   [NI];
  logic       e_m2reg  [NI];
  logic       e_wmem   [NI];
  logic [3:0] e_aluc   [NI];
  logic       e_aluimm [NI];
  logic [4:0] e_dest   [NI];
  logic [1:0] e_fwda   [NI];
  logic [1:0] e_fwdb   [NI];
  logic       e_illegal[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .REG_AW(5), .ALUC_W(4), .LOAD_STALL(g + 1)
    ) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid[g]),
      .op(op[g]), .funct(funct[g]),
      .rs(rs[g]), .rt(rt[g]), .rd(rd[g]),
      .m_dest(m_dest[g]), .m_wreg(m_wreg[g]), .m_m2reg(m_m2reg[g]),
      .stall(stall[g]), .e_wreg(e_wreg[g]), .e_m2reg(e_m2reg[g]),
      .e_wmem(e_wmem[g]), .e_aluc(e_aluc[g]), .e_aluimm(e_aluimm[g]),
      .e_dest(e_dest[g]), .e_fwda(e_fwda[g]), .e_fwdb(e_fwdb[g]),
      .e_illegal(e_illegal[g])
    );
  end

  int    errors = 0;
  int    checks = 0;
  ins_t  prog[$];
  int    pc  [NI];
  int    rem [NI];
  mctl_t mex [NI];
  mctl_t mmem[NI];

  // Spec-level decode table
  function automatic mctl_t mdec(input ins_t i,
                                 output logic ru, output logic tu);
    mctl_t c;
    c  = '0;
    ru = 1'b0;
    tu = 1'b0;
    if (i.op == 6'b000000) begin
      c.wreg = 1'b1; c.dest = i.rd; ru = 1'b1; tu = 1'b1;
      case (i.funct)
        6'b100000: c.aluc = 4'b0010;
        6'b100010: c.aluc = 4'b0110;
        6'b100100: c.aluc = 4'b0000;
        6'b100101: c.aluc = 4'b0001;
        6'b100110: c.aluc = 4'b1100;
        default: begin c = '0; c.ill = 1'b1; ru = 1'b0; tu = 1'b0; end
      endcase
    end else if (i.op == 6'b100011) begin
      c.wreg = 1'b1; c.m2reg = 1'b1; c.aluimm = 1'b1;
      c.aluc = 4'b0010; c.dest = i.rt; ru = 1'b1;
    end else if (i.op == 6'b101011) begin
      c.wmem = 1'b1; c.aluimm = 1'b1; c.aluc = 4'b0010;
      c.dest = i.rd; ru = 1'b1; tu = 1'b1;
    end
`ifdef PHC_IMM_ALU_EN
    else if (i.op == 6'b001000 || i.op == 6'b001100 ||
             i.op == 6'b001101 || i.op == 6'b001110) begin
      c.wreg = 1'b1; c.aluimm = 1'b1; c.dest = i.rt; ru = 1'b1;
      c.aluc = (i.op == 6'b001000) ? 4'b0010 :
               (i.op == 6'b001100) ? 4'b0000 :
               (i.op == 6'b001101) ? 4'b0001 : 4'b1100;
    end
`endif
    else c.ill = 1'b1;
    return c;
  endfunction

  function automatic logic [1:0] mfwd(input logic [4:0] r,
                                      input logic u, input int k);
    if (!u || r == 5'd0) return 2'b00;
    if (mex[k].wreg && !mex[k].m2reg && mex[k].dest == r) return 2'b01;
    if (mmem[k].wreg && mmem[k].dest == r)
      return mmem[k].m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f,
                              input int s, input int t, input int d);
    ins_t i;
    i.v = 1'b1; i.op = o; i.funct = f;
    i.rs = 5'(s); i.rt = 5'(t); i.rd = 5'(d);
    return i;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mex[k] = '0; mmem[k] = '0; rem[k] = 0; pc[k] = 0;
    end
  endtask

  // One clock: drive ID, check stall, clock, check ID/EX.
  task automatic cycle();
    mctl_t nx [NI];
    logic  es [NI];
    int    adv[NI];
    mctl_t act;
    for (int k = 0; k < NI; k++) begin
      ins_t  i;
      mctl_t d;
      logic  ru, tu;
      i = (pc[k] < prog.size()) ? prog[pc[k]] : '0;
      if_valid[k] = i.v; op[k] = i.op; funct[k] = i.funct;
      rs[k] = i.rs; rt[k] = i.rt; rd[k] = i.rd;
      m_dest[k] = mmem[k].dest; m_wreg[k] = mmem[k].wreg;
      m_m2reg[k] = mmem[k].m2reg;
      d = mdec(i, ru, tu);
      if (!i.v) begin ru = 1'b0; tu = 1'b0; end
      if (rem[k] > 0) begin
        es[k] = 1'b1; nx[k] = '0; rem[k]--; adv[k] = 0;
      end else if (i.v && mex[k].wreg && mex[k].m2reg &&
                   mex[k].dest != 5'd0 &&
                   ((ru && i.rs == mex[k].dest) ||
                    (tu && i.rt == mex[k].dest))) begin
        es[k] = 1'b1; nx[k] = '0; rem[k] = k; adv[k] = 0;
      end else begin
        es[k] = 1'b0; adv[k] = 1;
        nx[k] = i.v ? d : '0;
        if (i.v) begin
          nx[k].fwda = mfwd(i.rs, ru, k);
          nx[k].fwdb = mfwd(i.rt, tu, k);
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (stall[k] !== es[k]) begin
        errors++;
        $display("FAIL stall inst%0d pc=%0d got=%b exp=%b",
                 k, pc[k], stall[k], es[k]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      mmem[k] = mex[k];
      mex[k]  = nx[k];
      pc[k]  += adv[k];
      act = {e_wreg[k], e_m2reg[k], e_wmem[k], e_aluc[k], e_aluimm[k],
             e_dest[k], e_fwda[k], e_fwdb[k], e_illegal[k]};
      checks++;
      if (act !== mex[k]) begin
        errors++;
        $display("FAIL idex inst%0d pc=%0d got=%h exp=%h",
                 k, pc[k], act, mex[k]);
      end
    end
  endtask

  task automatic run_prog();
    int n;
    bit busy;
    for (int j = 0; j < 4; j++) prog.push_back('0);
    for (int k = 0; k < NI; k++) pc[k] = 0;
    n = 0;
    busy = 1'b1;
    while (busy && n < 2000) begin
      cycle();
      n++;
      busy = 1'b0;
      for (int k = 0; k < NI; k++)
        if (pc[k] < prog.size()) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL timeout got=%0d cycles exp=drained", n);
    end
  endtask

  task automatic check_zero(input string nm);
    mctl_t act;
    for (int k = 0; k < NI; k++) begin
      act = {e_wreg[k], e_m2reg[k], e_wmem[k], e_aluc[k], e_aluimm[k],
             e_dest[k], e_fwda[k], e_fwdb[k], e_illegal[k]};
      checks++;
      if (act !== '0 || stall[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d got=%h stall=%b exp=0 stall=0",
                 nm, k, act, stall[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if_valid[k] = 0; op[k] = 0; funct[k] = 0; rs[k] = 0; rt[k] = 0;
      rd[k] = 0; m_dest[k] = 0; m_wreg[k] = 0; m_m2reg[k] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_fwd_exa();
    prog = {};
    prog.push_back(mk(6'b000000, 6'b100000, 1, 2, 3));
    prog.push_back(mk(6'b000000, 6'b100010, 3, 1, 4));
    run_prog();
  endtask

  task automatic test_load_use();
    prog = {};
    prog.push_back(mk(6'b100011, 6'b0, 1, 5, 0));
    prog.push_back(mk(6'b000000, 6'b100000, 5, 2, 6));
    prog.push_back(mk(6'b100011, 6'b0, 1, 7, 0));
    prog.push_back(mk(6'b000000, 6'b100101, 2, 7, 8));
    run_prog();
  endtask

  task automatic test_reg0();
    prog = {};
    prog.push_back(mk(6'b100011, 6'b0, 1, 0, 0));
    prog.push_back(mk(6'b000000, 6'b100000, 0, 0, 6));
    prog.push_back(mk(6'b101011, 6'b0, 1, 2, 3));
    prog.push_back('0);
    prog.push_back(mk(6'b000000, 6'b100110, 3, 1, 4));
    prog.push_back(mk(6'b000000, 6'b100100, 1, 2, 3));
    prog.push_back('0);
    prog.push_back(mk(6'b000000, 6'b100000, 3, 3, 5));
    run_prog();
  endtask

  task automatic test_imm();
    prog = {};
    prog.push_back(mk(6'b001000, 6'b000101, 1, 2, 9));
    prog.push_back(mk(6'b001110, 6'b0, 2, 3, 0));
    prog.push_back(mk(6'b000000, 6'b111111, 2, 3, 4));
    prog.push_back(mk(6'b000000, 6'b100000, 2, 3, 4));
    run_prog();
  endtask

  task automatic test_store_fwd();
    prog = {};
    prog.push_back(mk(6'b000000, 6'b100000, 1, 2, 7));
    prog.push_back(mk(6'b101011, 6'b0, 1, 7, 0));
    prog.push_back(mk(6'b000000, 6'b100000, 1, 2, 7));
    prog.push_back(mk(6'b100011, 6'b0, 1, 7, 0));
    prog.push_back(mk(6'b101011, 6'b0, 2, 7, 0));
    run_prog();
  endtask

  task automatic test_random();
    logic [5:0] fl[5];
    logic [5:0] il[4];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
    il = '{6'b001000, 6'b001100, 6'b001101, 6'b001110};
    prog = {};
    for (int j = 0; j < 400; j++) begin
      ins_t i;
      int   s;
      s = $urandom_range(0, 9);
      i = mk(6'b0, fl[$urandom_range(0, 4)], $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      if (s == 5 || s == 6) i.op = 6'b100011;
      else if (s == 7) i.op = 6'b101011;
      else if (s == 8) i.op = il[$urandom_range(0, 3)];
      else if (s == 9) begin
        i.op = 6'($urandom);
        i.funct = 6'($urandom);
      end
      i.v = ($urandom_range(0, 7) != 0);
      prog.push_back(i);
    end
    run_prog();
  endtask

  task automatic test_rst_mid_stall();
    prog = {};
    prog.push_back(mk(6'b100011, 6'b0, 1, 5, 0));
    prog.push_back(mk(6'b000000, 6'b100000, 5, 2, 6));
    for (int k = 0; k < NI; k++) pc[k] = 0;
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid_stall");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    test_fwd_exa();
  endtask

  initial begin
    test_reset();
    test_fwd_exa();
    test_load_use();
    test_reg0();
    test_imm();
    test_store_fwd();
    test_random();
    test_rst_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
